// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit and receive paths.
//   UART_DATA_W      serial character width
//   UART_FIFO_DEPTH  default byte-FIFO depth (TX buffer and RX FIFO)
//   tx_state_t       drain FSM states of the transmit buffer
//   uart_push_t      byte push request from the CPU store path
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_FIFO_DEPTH = 16;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_t;

    typedef struct packed {
        logic       vld;
        uart_byte_t data;
    } uart_push_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock circular FIFO, reused on both sides of the UART.
//   clk, reset   rising-edge clock, synchronous active-high reset
//   push         enqueue request; ignored (and flagged on drop) when full
//   push_data    word to enqueue
//   pop          dequeue request; ignored when empty
//   pop_data     word at the head (valid while empty=0), no fall-through
//   full/empty   decoded from the registered count
//   count        number of stored words, 0..DEPTH
//   drop         push attempted while full (combinational, this cycle)
// ---------------------------------------------------------------------------
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH  = UART_FIFO_DEPTH,
    parameter  int WIDTH  = UART_DATA_W,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [WIDTH-1:0]  push_data,
    input  logic              pop,
    output logic [WIDTH-1:0]  pop_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              drop
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    // Full/empty come from the registered count, so a pop in the same
    // cycle never makes room for a push into a full FIFO.
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign drop     = push && full;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are exactly ADDR_W bits wide, so DEPTH being a power of two
    // lets them wrap without any compare.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// ---------------------------------------------------------------------------
// uart_tx_buffer
// Byte FIFO plus drain FSM feeding the UART transmitter. CPU stores are
// queued and handed out one at a time, paced on the transmitter's busy.
//   clk_100MHz    system clock, rising edge
//   reset         synchronous, active-high
//   wr_en/wr_data byte push from the CPU store path
//   clr_overflow  clears the sticky overflow flag (a same-cycle drop wins)
//   tx_busy       transmitter busy
//   tx_start      one-cycle registered start pulse
//   tx_data       byte presented to the transmitter, held until the
//                 transmitter has finished with it
//   full/empty    FIFO status
//   count         queued bytes, excluding the one in flight
//   overflow      sticky: a push was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter  int DEPTH  = UART_FIFO_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk_100MHz,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic                   clr_overflow,
    input  logic                   tx_busy,
    output logic                   tx_start,
    output logic [UART_DATA_W-1:0] tx_data,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_W:0]        count,
    output logic                   overflow
);

    uart_push_t  push_req;
    uart_byte_t  head_data;
    logic        drop;
    logic        pop;
    tx_state_t   state;
    tx_state_t   state_nxt;

    assign push_req = '{vld: wr_en, data: wr_data};

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .clk       (clk_100MHz),
        .reset     (reset),
        .push      (push_req.vld),
        .push_data (push_req.data),
        .pop       (pop),
        .pop_data  (head_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .drop      (drop)
    );

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // START ignores tx_busy: the transmitter only reacts to the pulse after
    // it is seen, so acknowledgement is looked for from WAIT_ACK onwards.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !tx_busy) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START:     state_nxt = WAIT_ACK;
            WAIT_ACK:  if (tx_busy)  state_nxt = WAIT_DONE;
            WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // tx_start is high exactly while the FSM sits in START; registering the
    // pop keeps wr_en/tx_busy off any combinational path to the outputs.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            tx_start <= 1'b0;
            tx_data  <= '0;
            overflow <= 1'b0;
        end else begin
            tx_start <= pop;
            if (pop) begin
                tx_data <= head_data;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
